mips_cpu_muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that owns the architectural Hi/Lo registers. It replaces the single-cycle combinational MUL/DIV/MTHI/MTLO path. It sits beside the ALU in the execute stage: it accepts one operation via a valid/ready handshake, runs a pipelined multiply or an iterative radix-2 divide, and raises busy so the control unit stalls MFHI/MFLO and further mul/div ops. A flush input cancels an in-flight op on exception or branch squash.

---
 rtl/mips_cpu_muldiv_pkg.sv | 38 +++
 rtl/mips_cpu_div_iter.sv | 69 ++++++
 rtl/mips_cpu_muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_mips_cpu_muldiv_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the Hi/Lo multiply/divide unit: op codes, FSM states, divide-by-zero fill.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_cpu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7    // decoded as NOP
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MUL       = 3'd1,
        ST_DIV_PRE   = 3'd2,
        ST_DIV_ITER  = 3'd3,
        ST_DIV_POST  = 3'd4,
        ST_WRITEBACK = 3'd5
    } muldiv_state_t;

    // Divide by zero: every quotient bit is set (Lo = all ones) and the remainder
    // is the untouched dividend (Hi = a), independent of signedness.
    localparam logic DIV0_QUO_BIT = 1'b1;

    function automatic logic is_mul_op(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mips_cpu_div_iter.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// Latency: WIDTH cycles after start; done pulses the cycle quotient/remainder are final.
// Backpressure: none; start restarts unconditionally, owner must not start while it waits.
// Ports: clk/rst (sync, active-high), start loads dividend/divisor,
//        quotient/remainder hold the result, done is a one-cycle pulse.
module mips_cpu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;    // dividend bits shift out the top, quotient bits in at the bottom
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             active_q;
    logic             done_q;

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             fits;

    // Partial remainder is always < divisor, so the shifted value fits in WIDTH+1 bits.
    always_comb begin
        partial = {rem_q, quo_q[WIDTH-1]};
        diff    = partial - {1'b0, dvs_q};
        fits    = !diff[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (start) begin
            rem_q    <= '0;
            quo_q    <= dividend;
            dvs_q    <= divisor;
            cnt_q    <= CW'(WIDTH);
            active_q <= 1'b1;
            done_q   <= 1'b0;
        end else if (active_q) begin
            rem_q    <= fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
            quo_q    <= {quo_q[WIDTH-2:0], fits};
            cnt_q    <= cnt_q - CW'(1);
            done_q   <= (cnt_q == CW'(1));
            active_q <= (cnt_q != CW'(1));
        end else begin
            done_q   <= 1'b0;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/mips_cpu_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the architectural Hi/Lo registers.
// Latency: multiply MUL_LATENCY cycles, divide WIDTH+3 cycles, MTHI/MTLO 1 cycle.
// Backpressure: op_ready = !busy; requests while busy are ignored and must be held.
// Ports: clk/rst (sync, active-high); op_valid/op_ready handshake with op, a, b;
//        flush cancels the in-flight op; busy, done pulse, hi/lo architectural registers.
module mips_cpu_muldiv_unit
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] MUL_LAST = (MUL_LATENCY >= 2) ? CW'(MUL_LATENCY - 2) : '0;
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    muldiv_state_t     state_q, state_d;
    muldiv_op_t        op_in, op_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic [WIDTH-1:0]  div_hi_q, div_lo_q;
    logic [CW-1:0]     cnt_q;
    logic              q_neg_q, r_neg_q, div_zero_q;

    logic              accept, take, wb_fire;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic              div_signed, a_neg, b_neg;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [WIDTH-1:0]  res_hi, res_lo;
    logic              div_start, div_done;
    logic [WIDTH-1:0]  div_quo, div_rem;

    assign op_in  = muldiv_op_t'(op);
    assign accept = op_valid && op_ready;
    assign take   = accept && !flush;     // a flush in the accept cycle drops the op

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    if (is_mul_op(op_in))
                        state_d = (MUL_LATENCY == 1) ? ST_WRITEBACK : ST_MUL;
                    else if (is_div_op(op_in))
                        state_d = ST_DIV_PRE;
                end
            end
            ST_MUL:       if (cnt_q == MUL_LAST) state_d = ST_WRITEBACK;
            ST_DIV_PRE:   state_d = ST_DIV_ITER;
            ST_DIV_ITER:  if (cnt_q == DIV_LAST) state_d = ST_DIV_POST;
            ST_DIV_POST:  state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        if (flush && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    // ---------------- FSM: outputs ----------------
    // The result is shown on hi/lo combinationally during WRITEBACK so it is visible
    // in that cycle while a same-cycle flush can still suppress it.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        op_ready  = !busy;
        wb_fire   = (state_q == ST_WRITEBACK) && !flush;
        done      = wb_fire;
        div_start = (state_q == ST_DIV_PRE);
        hi        = wb_fire ? res_hi : hi_q;
        lo        = wb_fire ? res_lo : lo_q;
    end

    // Cycle counter shared by the MUL wait and the divide iterations; restarts on entry.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (state_d == state_q && (state_q == ST_MUL || state_q == ST_DIV_ITER))
            cnt_q <= cnt_q + CW'(1);
        else
            cnt_q <= '0;
    end

    // ---------------- Operand capture ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= OP_NOP;
            a_q  <= '0;
            b_q  <= '0;
        end else if (take) begin
            op_q <= op_in;
            a_q  <= a;
            b_q  <= b;
        end
    end

    // ---------------- Multiply ----------------
    // Sign-extending both operands to 2*WIDTH makes the low 2*WIDTH bits of an
    // unsigned product equal the two's-complement signed product.
    always_comb begin
        a_ext = {{WIDTH{(op_q == OP_MULT) & a_q[WIDTH-1]}}, a_q};
        b_ext = {{WIDTH{(op_q == OP_MULT) & b_q[WIDTH-1]}}, b_q};
        prod  = a_ext * b_ext;
    end

    // ---------------- Divide sign handling ----------------
    // Negating the most-negative value wraps to itself, which is its correct
    // unsigned magnitude, so MIN / -1 falls out as quotient MIN, remainder 0.
    always_comb begin
        div_signed = (op_q == OP_DIV);
        a_neg      = div_signed & a_q[WIDTH-1];
        b_neg      = div_signed & b_q[WIDTH-1];
        mag_a      = a_neg ? (~a_q + WIDTH'(1)) : a_q;
        mag_b      = b_neg ? (~b_q + WIDTH'(1)) : b_q;
    end

    mips_cpu_div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            div_hi_q   <= '0;
            div_lo_q   <= '0;
        end else begin
            if (state_q == ST_DIV_PRE) begin
                q_neg_q    <= a_neg ^ b_neg;
                r_neg_q    <= a_neg;
                div_zero_q <= (b_q == '0);
            end
            if (state_q == ST_DIV_POST && div_done) begin
                if (div_zero_q) begin
                    div_lo_q <= {WIDTH{DIV0_QUO_BIT}};
                    div_hi_q <= a_q;
                end else begin
                    div_lo_q <= q_neg_q ? (~div_quo + WIDTH'(1)) : div_quo;
                    div_hi_q <= r_neg_q ? (~div_rem + WIDTH'(1)) : div_rem;
                end
            end
        end
    end

    always_comb begin
        res_hi = is_mul_op(op_q) ? prod[2*WIDTH-1:WIDTH] : div_hi_q;
        res_lo = is_mul_op(op_q) ? prod[WIDTH-1:0]       : div_lo_q;
    end

    // ---------------- Architectural Hi/Lo ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_fire) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (take) begin
            if (op_in == OP_MTHI) hi_q <= a;
            if (op_in == OP_MTLO) lo_q <= a;
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Self-checking bench for mips_cpu_muldiv_unit: directed vector table, hand-written
// flush/busy/reset sequences, and random ops against an arithmetic reference model.
// Inputs are driven 1 time unit after the rising edge, outputs sampled there too.
module tb_mips_cpu_muldiv_unit;
    import mips_cpu_muldiv_pkg::*;

    localparam int W       = 32;
    localparam int L       = 2;
    localparam int DIV_LAT = W + 3;

    logic         clk = 1'b0;
    logic         rst, op_valid, op_ready, flush, busy, done;
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] m_hi, m_lo;   // bench's view of architectural Hi/Lo

    always #5 clk = ~clk;

    mips_cpu_muldiv_unit #(.WIDTH(W), .MUL_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural rules.
    function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                   inout logic [W-1:0] h, inout logic [W-1:0] l);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     t, r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = {32'b0, av};
        ub = {32'b0, bv};
        case (o)
            3'd1: begin t = sa * sb; h = t[63:32]; l = t[31:0]; end
            3'd2: begin t = ua * ub; h = t[63:32]; l = t[31:0]; end
            3'd3: begin
                if (bv == 0) begin l = '1; h = av; end
                else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin l = av; h = '0; end
                else begin t = sa / sb; r = sa % sb; l = t[31:0]; h = r[31:0]; end
            end
            3'd4: begin
                if (bv == 0) begin l = '1; h = av; end
                else begin t = ua / ub; r = ua % ub; l = t[31:0]; h = r[31:0]; end
            end
            3'd5: h = av;
            3'd6: l = av;
            default: ;
        endcase
    endfunction

    // Issue one op from idle, check latency, result and post-done state.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input string nm);
        int lat;
        bit is_md;
        is_md    = (o >= 3'd1 && o <= 3'd4);
        op_valid = 1'b1; op = o; a = av; b = bv;
        tick();                                   // cycle T+1
        op_valid = 1'b0;
        op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;   // operands need not be held
        if (!is_md) begin
            check({nm, " busy"}, 32'(busy), 32'd0);
            check({nm, " hi"}, hi, eh);
            check({nm, " lo"}, lo, el);
        end else begin
            check({nm, " busy"}, 32'(busy), 32'd1);
            lat = 1;
            while (!done && lat < 200) begin
                tick();
                lat++;
            end
            check({nm, " latency"}, 32'(lat), (o <= 3'd2) ? 32'(L) : 32'(DIV_LAT));
            check({nm, " hi"}, hi, eh);
            check({nm, " lo"}, lo, el);
            tick();
            check({nm, " done_once"}, 32'(done), 32'd0);
            check({nm, " ready_after"}, 32'(op_ready), 32'd1);
            check({nm, " hi_kept"}, hi, eh);
            check({nm, " lo_kept"}, lo, el);
        end
        m_hi = eh;
        m_lo = el;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, eh, el;
        string        nm;
    } vec_t;

    vec_t vecs[13];

    initial begin
        bit seen;
        int lat;
        logic [W-1:0] eh, el, av, bv;
        logic [2:0] o;

        vecs[0]  = '{3'd5, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0,         "mthi"};
        vecs[1]  = '{3'd6, 32'h9ABC_DEF0, 32'h0,         32'h1234_5678, 32'h9ABC_DEF0, "mtlo"};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg"};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, "multu"};
        vecs[4]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg"};
        vecs[5]  = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        "divu"};
        vecs[6]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, "div_ovf"};
        vecs[7]  = '{3'd4, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, "divu_zero"};
        vecs[8]  = '{3'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero"};
        vecs[9]  = '{3'd0, 32'h5555_5555, 32'd9,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "nop"};
        vecs[10] = '{3'd7, 32'h6666_6666, 32'd9,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "rsvd"};
        vecs[11] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_negb"};
        vecs[12] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};

        rst = 1'b1; op_valid = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
        tick(); tick();
        check("rst hi", hi, 32'h0);
        check("rst lo", lo, 32'h0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst ready", 32'(op_ready), 32'd1);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        tick();

        for (int i = 0; i < 13; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].nm);

        // Flush mid-divide at T+10: idle at T+11, no done, Hi/Lo untouched.
        op_valid = 1'b1; op = 3'd3; a = 32'd100; b = 32'd3;
        tick();
        op_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush ready", 32'(op_ready), 32'd1);
        check("flush hi", hi, m_hi);
        check("flush lo", lo, m_lo);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("flush no_done", 32'(seen), 32'd0);
        check("flush hi_late", hi, m_hi);

        // Request during busy is ignored until the divide completes.
        op_valid = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd10;
        tick();
        op_valid = 1'b0;
        tick(); tick();
        op_valid = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
        tick(); tick();
        lat = 5;
        check("busy_req ready", 32'(op_ready), 32'd0);
        check("busy_req hi", hi, m_hi);
        op_valid = 1'b0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        check("busy_req latency", 32'(lat), 32'(DIV_LAT));
        check("busy_req lo", lo, 32'd100);
        check("busy_req hi_res", hi, 32'd0);
        m_hi = 32'd0; m_lo = 32'd100;
        tick();

        // Flush in the accept cycle discards the op.
        op_valid = 1'b1; op = 3'd5; a = 32'hCAFE_F00D; flush = 1'b1;
        tick();
        op_valid = 1'b0; flush = 1'b0;
        check("acc_flush hi", hi, m_hi);
        check("acc_flush busy", 32'(busy), 32'd0);

        // Flush in the writeback cycle suppresses the result.
        op_valid = 1'b1; op = 3'd2; a = 32'd3; b = 32'd4;
        tick();
        op_valid = 1'b0;
        tick();
        check("wb_flush done_pre", 32'(done), 32'd1);
        flush = 1'b1;
        #1;
        check("wb_flush done", 32'(done), 32'd0);
        check("wb_flush lo_out", lo, m_lo);
        tick();
        flush = 1'b0;
        check("wb_flush busy", 32'(busy), 32'd0);
        check("wb_flush hi", hi, m_hi);
        check("wb_flush lo", lo, m_lo);

        // Reset mid-divide.
        op_valid = 1'b1; op = 3'd3; a = 32'hFFFF_FFF9; b = 32'd2;
        tick();
        op_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst hi", hi, 32'h0);
        check("midrst lo", lo, 32'h0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst ready", 32'(op_ready), 32'd1);
        m_hi = '0; m_lo = '0;
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "post_rst_multu");

        // Random ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            o  = 3'($urandom_range(1, 6));
            av = $urandom;
            case ($urandom_range(0, 3))
                0:       bv = '0;
                1:       bv = 32'($urandom_range(1, 9));
                2:       bv = 32'hFFFF_FFFF;
                default: bv = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) av = 32'h8000_0000;
            eh = m_hi; el = m_lo;
            ref_op(o, av, bv, eh, el);
            do_op(o, av, bv, eh, el, $sformatf("rand%0d_op%0d", i, o));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
